alu_exec_unit: RTL and testbench

- Execute stage that consumes the 4-bit aluoperation code from the ALU control decoder.
- Takes operands A and B, runs the selected operation, and returns a registered result, zero flag and done pulse.
- Simple ops complete in 1 cycle; MUL is iterative shift-add over WIDTH cycles.
- Uses a start/busy/done handshake so the datapath controller can stall on multi-cycle ops.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_exec_unit_if.sv | 16 +
 rtl/alu_seq_muldiv.sv | 88 ++++++++
 rtl/alu_exec_unit.sv | 114 +++++++++++
 tb/tb_alu_exec_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the ALU execute stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// start/busy/done handshake plus operand and result bus of the execute stage.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       aluoperation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output start, aluoperation, a, b, input result, zero, busy, done);
  modport slave  (input start, aluoperation, a, b, output result, zero, busy, done);
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier; restoring divider added when ALU_EXEC_DIV_EN is defined.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] value,
  output logic             finished
);

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_nxt, mcand_nxt, mplier_nxt;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             div_q;

  // finished flags the cycle in which the last iteration is applied
  assign finished = active && (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_EXEC_DIV_EN
  logic [WIDTH:0] shifted, diff;

  assign value = div_q ? mplier : acc;

  // For division: acc is the partial remainder, mplier shifts the dividend out and the quotient in
  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    shifted    = {acc, mplier[WIDTH-1]};
    diff       = shifted - {1'b0, mcand};
    if (div_q) begin
      mcand_nxt = mcand;
      if (!diff[WIDTH]) begin
        acc_nxt    = diff[WIDTH-1:0];
        mplier_nxt = {mplier[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt    = shifted[WIDTH-1:0];
        mplier_nxt = {mplier[WIDTH-2:0], 1'b0};
      end
    end else if (mplier[0]) begin
      acc_nxt = acc + mcand;
    end
  end
`else
  logic unused_is_div;

  assign unused_is_div = is_div;
  assign value         = acc;

  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    if (mplier[0]) acc_nxt = acc + mcand;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= is_div ? b : a;
      mplier <= is_div ? a : b;
      cnt    <= '0;
      active <= 1'b1;
      div_q  <= is_div;
    end else if (active) begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt + 1'b1;
      if (finished) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: handshake FSM, single-cycle op mux and registered result/zero.
// Op 0111 is a divide when ALU_EXEC_DIV_EN is defined, otherwise it executes as ADD.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic             clk,
  input logic             rst,
  alu_exec_unit_if.slave  bus
);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             seq_op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, busy_q, done_q;
  logic             accept, seq_start, is_seq_op, is_div;
  logic             seq_finished;
  logic [WIDTH-1:0] seq_val, simple_val, fin_val;

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

`ifdef ALU_EXEC_DIV_EN
  assign is_div = (bus.aluoperation == OP_DIV);
`else
  assign is_div = 1'b0;
`endif
  assign is_seq_op = (bus.aluoperation == OP_MUL) || is_div;

  // busy_q stays high through the done cycle, so a new start waits one extra cycle
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    seq_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !busy_q) begin
          accept = 1'b1;
          if (is_seq_op) begin
            seq_start = 1'b1;
            state_d   = EXEC;
          end else begin
            state_d = FIN;
          end
        end
      end
      EXEC:    if (seq_finished) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SUB:  simple_val = a_q - b_q;
      OP_AND:  simple_val = a_q & b_q;
      OP_OR:   simple_val = a_q | b_q;
      OP_SLT:  simple_val = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_NOR:  simple_val = ~(a_q | b_q);
      default: simple_val = a_q + b_q;
    endcase
  end

  assign fin_val = seq_op_q ? seq_val : simple_val;

  alu_seq_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
    .is_div   (is_div),
    .a        (bus.a),
    .b        (bus.b),
    .value    (seq_val),
    .finished (seq_finished)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      seq_op_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIN);
      busy_q  <= accept || (state_q == EXEC) || (state_q == FIN);
      if (accept) begin
        op_q     <= bus.aluoperation;
        a_q      <= bus.a;
        b_q      <= bus.b;
        seq_op_q <= is_seq_op;
      end
      if (state_q == FIN) begin
        result_q <= fin_val;
        zero_q   <= (fin_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit; expected results queued at start, compared on done.
module tb_alu_exec_unit;

  localparam int W       = 32;
  localparam int LAT_SMP = 2;
  localparam int LAT_SEQ = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Independent reference model
  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: return ~(a | b);
      4'd6: return a * b;
`ifdef ALU_EXEC_DIV_EN
      4'd7: return (b == 0) ? 32'hFFFF_FFFF : a / b;
`endif
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef ALU_EXEC_DIV_EN
    if (op == 4'd7) return LAT_SEQ;
`endif
    return (op == 4'd6) ? LAT_SEQ : LAT_SMP;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%h with no pending expectation", bus.result);
      end else begin
        e = sb.pop_front();
        if (bus.result !== e.res) begin
          errors++;
          $display("FAIL result: got %h expected %h", bus.result, e.res);
        end
        checks++;
        if (bus.zero !== e.z) begin
          errors++;
          $display("FAIL zero: got %b expected %b (result %h)", bus.zero, e.z, e.res);
        end
      end
    end
  end

  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.aluoperation = op;
    bus.a            = a;
    bus.b            = b;
    sb.push_back('{res: exp, z: (exp == '0)});
  endtask

  // Returns the number of negedges from the start cycle to done, or -1 on timeout
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        bus.start        = 1'b0;
        bus.a            = $urandom;
        bus.b            = $urandom;
        bus.aluoperation = 4'($urandom);
      end
    end while (bus.done !== 1'b1 && cycles < limit);
    if (bus.done !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset;
    int cyc;
    bus.start = 1'b0; bus.aluoperation = '0; bus.a = '0; bus.b = '0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_op(4'd0, 32'd9, 32'd9, 32'd18);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL pre_reset_latency: got %0d expected %0d", cyc, LAT_SMP); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got result=%h zero=%b done=%b busy=%b expected 0/1/0/0",
               bus.result, bus.zero, bus.done, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_sub;
    int cyc;
    drive_op(4'd0, 32'd5, 32'd7, 32'd12);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL add_latency: got %0d expected %0d", cyc, LAT_SMP); end
    drive_op(4'd1, 32'd7, 32'd7, 32'd0);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL sub_latency: got %0d expected %0d", cyc, LAT_SMP); end
  endtask

  task automatic test_slt_nor;
    int cyc;
    drive_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL slt_latency: got %0d expected %0d", cyc, LAT_SMP); end
    drive_op(4'd4, 32'd1, 32'hFFFF_FFFF, 32'd0);
    wait_done(10, cyc);
    drive_op(4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL nor_latency: got %0d expected %0d", cyc, LAT_SMP); end
  endtask

  task automatic test_mul_ignore;
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    drive_op(4'd6, 32'd1000, 32'd3000, 32'd3000000);
    for (int c = 1; c <= LAT_SEQ + 6; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 10) begin
        bus.start = 1'b1; bus.aluoperation = 4'd0; bus.a = 32'd1; bus.b = 32'd1;
      end
      if (c == 11) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin done_cnt++; done_at = c; end
    end
    checks++; if (done_at !== LAT_SEQ) begin errors++; $display("FAIL mul_done_cycle: got %0d expected %0d", done_at, LAT_SEQ); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mul_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_cnt !== LAT_SEQ) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected %0d", busy_cnt, LAT_SEQ); end
  endtask

  task automatic test_mul_wrap_abort;
    int cyc, done_cnt = 0;
    drive_op(4'd6, 32'h8000_0000, 32'd2, 32'd0);
    wait_done(LAT_SEQ + 5, cyc);
    checks++; if (cyc !== LAT_SEQ) begin errors++; $display("FAIL mul_wrap_latency: got %0d expected %0d", cyc, LAT_SEQ); end
    drive_op(4'd6, 32'd3, 32'd5, 32'd15);
    wait_done(LAT_SEQ + 5, cyc);
    drive_op(4'd6, 32'd1000, 32'd3000, 32'd3000000);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got result=%h zero=%b done=%b busy=%b expected 0/1/0/0",
               bus.result, bus.zero, bus.done, bus.busy);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < LAT_SEQ + 5; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt); end
  endtask

  task automatic test_opcode7;
    int cyc;
`ifdef ALU_EXEC_DIV_EN
    drive_op(4'd7, 32'd100, 32'd7, 32'd14);
    wait_done(LAT_SEQ + 5, cyc);
    checks++; if (cyc !== LAT_SEQ) begin errors++; $display("FAIL div_latency: got %0d expected %0d", cyc, LAT_SEQ); end
    drive_op(4'd7, 32'd100, 32'd0, 32'hFFFF_FFFF);
    wait_done(LAT_SEQ + 5, cyc);
    checks++; if (cyc !== LAT_SEQ) begin errors++; $display("FAIL div0_latency: got %0d expected %0d", cyc, LAT_SEQ); end
`else
    drive_op(4'd7, 32'd100, 32'd7, 32'd107);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL op7_add_latency: got %0d expected %0d", cyc, LAT_SMP); end
`endif
    drive_op(4'd15, 32'd3, 32'd4, 32'd7);
    wait_done(10, cyc);
    checks++; if (cyc !== LAT_SMP) begin errors++; $display("FAIL op15_latency: got %0d expected %0d", cyc, LAT_SMP); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] mask = '0;
    drive_op(4'd0, 32'd2, 32'd3, 32'd5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      mask[c] = (bus.done === 1'b1);
      case (c)
        1: begin bus.start = 1'b1; bus.aluoperation = 4'd1; bus.a = 32'd9; bus.b = 32'd1; end
        2: begin
          bus.aluoperation = 4'd3; bus.a = 32'hF0; bus.b = 32'h0F;
          sb.push_back('{res: 32'hFF, z: 1'b0});
        end
        4: begin bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; end
        default: ;
      endcase
    end
    checks++; if (mask !== 10'b00_0010_0100) begin errors++; $display("FAIL b2b_done_pattern: got %b expected %b", mask, 10'b00_0010_0100); end
  endtask

  task automatic test_random;
    int cyc;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i == 3) ? a : $urandom;
      drive_op(op, a, b, ref_op(op, a, b));
      wait_done(LAT_SEQ + 5, cyc);
      checks++; if (cyc !== ref_lat(op)) begin errors++; $display("FAIL rand_latency op=%0d: got %0d expected %0d", op, cyc, ref_lat(op)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_slt_nor();
    test_mul_ignore();
    test_mul_wrap_abort();
    test_opcode7();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL pending_results: got %0d outstanding expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
